// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap/MRET sequencer that owns the CSR write port during trap entry and exit.
module trap_controller #(
    parameter logic [31:0] MSTATUS_MASK = 32'h00001888,
    parameter logic [31:0] MIE_MASK     = 32'h00000888
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_csr_write,
    input  logic [11:0] sw_csr_waddr,
    input  logic [31:0] sw_csr_wdata,
    output logic        csr_write,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic [31:0] int_pc,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    input  logic        mret_valid,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_MEPC    = 3'd1;
    localparam logic [2:0] W_MCAUSE  = 3'd2;
    localparam logic [2:0] W_MTVAL   = 3'd3;
    localparam logic [2:0] W_MSTATUS = 3'd4;
    localparam logic [2:0] W_MRET    = 3'd5;

    logic [2:0]  state;
    logic [31:0] sh_mstatus, sh_mie, sh_mtvec, sh_mepc;
    logic [31:0] epc, cause, tval;
    logic [31:0] pend, base, trap_pc, entry_mstatus, mret_mstatus;
    logic [3:0]  int_code;
    logic        idle, int_take;

    assign idle     = state == IDLE;
    assign pend     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0} & sh_mie;
    assign int_take = sh_mstatus[3] && pend != 32'b0;
    assign int_code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
    assign stall    = !idle || exc_valid || mret_valid || int_take;

    assign entry_mstatus = (sh_mstatus & ~MSTATUS_MASK) | 32'h00001800 | ({31'b0, sh_mstatus[3]} << 7);
    assign mret_mstatus  = (sh_mstatus & ~MSTATUS_MASK) | 32'h00001880 | ({31'b0, sh_mstatus[7]} << 3);
    assign base          = {sh_mtvec[31:2], 2'b00};
    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign trap_pc       = (sh_mtvec[1:0] == 2'b01 && cause[31]) ? base + {26'b0, cause[3:0], 2'b00} : base;

    always_comb begin
        csr_write      = idle ? sw_csr_write : 1'b1;
        csr_waddr      = idle ? (sw_csr_write ? sw_csr_waddr : 12'h000) :
                         state == W_MEPC   ? 12'h341 :
                         state == W_MCAUSE ? 12'h342 :
                         state == W_MTVAL  ? 12'h343 : 12'h300;
        csr_wdata      = idle ? (sw_csr_write ? sw_csr_wdata : 32'h0) :
                         state == W_MEPC    ? {epc[31:2], 2'b00} :
                         state == W_MCAUSE  ? cause :
                         state == W_MTVAL   ? tval :
                         state == W_MSTATUS ? entry_mstatus : mret_mstatus;
        redirect_valid = state == W_MSTATUS || state == W_MRET;
        redirect_pc    = state == W_MSTATUS ? trap_pc : state == W_MRET ? sh_mepc : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            epc        <= '0;
            cause      <= '0;
            tval       <= '0;
            sh_mstatus <= '0;
            sh_mie     <= '0;
            sh_mtvec   <= '0;
            sh_mepc    <= '0;
        end else begin
            if (csr_write) begin
                if (csr_waddr == 12'h300) sh_mstatus <= csr_wdata & MSTATUS_MASK;
                if (csr_waddr == 12'h304) sh_mie     <= csr_wdata & MIE_MASK;
                if (csr_waddr == 12'h305) sh_mtvec   <= csr_wdata;
                if (csr_waddr == 12'h341) sh_mepc    <= csr_wdata;
            end
            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        state <= W_MEPC;
                        epc   <= exc_pc;
                        cause <= {28'b0, exc_cause};
                        tval  <= exc_tval;
                    end else if (mret_valid) begin
                        state <= W_MRET;
                    end else if (int_take) begin
                        state <= W_MEPC;
                        epc   <= int_pc;
                        cause <= {1'b1, 27'b0, int_code};
                        tval  <= '0;
                    end
                end
                W_MEPC:    state <= W_MCAUSE;
                W_MCAUSE:  state <= W_MTVAL;
                W_MTVAL:   state <= W_MSTATUS;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed stimulus with a queue scoreboard checked by an independent port monitor.
module tb_trap_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_csr_write;
    logic [11:0] sw_csr_waddr;
    logic [31:0] sw_csr_wdata;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval, int_pc;
    logic        irq_ext, irq_timer, irq_soft, mret_valid;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic        rv;
        logic [31:0] rp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad = 0;

    trap_controller dut (
        .clk(clk), .rst_n(rst_n),
        .sw_csr_write(sw_csr_write), .sw_csr_waddr(sw_csr_waddr), .sw_csr_wdata(sw_csr_wdata),
        .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .int_pc(int_pc), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .mret_valid(mret_valid), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && (csr_write || redirect_valid)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL port_unexpected: got we=%0b a=%h d=%h rv=%0b rp=%h, expected nothing", csr_write, csr_waddr, csr_wdata, redirect_valid, redirect_pc);
            end else begin
                e = q.pop_front();
                if (!csr_write || csr_waddr !== e.a || csr_wdata !== e.d || redirect_valid !== e.rv || redirect_pc !== e.rp) begin
                    bad++;
                    $display("FAIL port_write: got we=%0b a=%h d=%h rv=%0b rp=%h, expected a=%h d=%h rv=%0b rp=%h",
                             csr_write, csr_waddr, csr_wdata, redirect_valid, redirect_pc, e.a, e.d, e.rv, e.rp);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d, input logic rv, input logic [31:0] rp);
        exp_t x;
        x.a = a; x.d = d; x.rv = rv; x.rp = rp;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_wr(input logic [11:0] a, input logic [31:0] d);
        sw_csr_write = 1'b1; sw_csr_waddr = a; sw_csr_wdata = d;
        push(a, d, 1'b0, 32'h0);
        tick();
        sw_csr_write = 1'b0; sw_csr_waddr = '0; sw_csr_wdata = '0;
    endtask

    task automatic busy(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("stall_busy", {31'b0, stall}, 32'h1);
            tick();
        end
        @(negedge clk);
        chk("stall_idle", {31'b0, stall}, 32'h0);
        tick();
    endtask

    task automatic exc(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
        exc_valid = 1'b1; exc_cause = c; exc_pc = pc; exc_tval = tv;
    endtask

    initial begin
        rst_n = 1'b0;
        sw_csr_write = 0; sw_csr_waddr = '0; sw_csr_wdata = '0;
        exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_tval = '0; int_pc = '0;
        irq_ext = 0; irq_timer = 0; irq_soft = 0; mret_valid = 0;
        #3;
        chk("rst_csr_write", {31'b0, csr_write}, 32'h0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // exception into direct-mode mtvec
        sw_wr(12'h305, 32'h100);
        exc(4'd2, 32'h80, 32'hDEADBEEF);
        push(12'h341, 32'h80, 0, 0); push(12'h342, 32'h2, 0, 0);
        push(12'h343, 32'hDEADBEEF, 0, 0); push(12'h300, 32'h1800, 1, 32'h100);
        @(negedge clk); chk("stall_accept_exc", {31'b0, stall}, 32'h1);
        tick(); exc_valid = 0;
        busy(4);

        // vectored timer interrupt
        sw_wr(12'h305, 32'h101);
        sw_wr(12'h300, 32'h8);
        sw_wr(12'h304, 32'h80);
        irq_timer = 1; int_pc = 32'h200;
        push(12'h341, 32'h200, 0, 0); push(12'h342, 32'h80000007, 0, 0);
        push(12'h343, 32'h0, 0, 0); push(12'h300, 32'h1880, 1, 32'h11C);
        @(negedge clk); chk("stall_accept_irq", {31'b0, stall}, 32'h1);
        tick();
        busy(4);

        // mret re-enables MIE; pending timer retaken immediately after
        mret_valid = 1;
        push(12'h300, 32'h1888, 1, 32'h200);
        push(12'h341, 32'h200, 0, 0); push(12'h342, 32'h80000007, 0, 0);
        push(12'h343, 32'h0, 0, 0); push(12'h300, 32'h1880, 1, 32'h11C);
        @(negedge clk); chk("stall_accept_mret", {31'b0, stall}, 32'h1);
        tick(); mret_valid = 0;
        @(negedge clk); chk("stall_w_mret", {31'b0, stall}, 32'h1);
        tick();
        @(negedge clk); chk("stall_retake_irq", {31'b0, stall}, 32'h1);
        tick(); irq_timer = 0;
        busy(4);

        // simultaneous exception, mret and interrupt: exception wins
        sw_wr(12'h300, 32'h8);
        sw_wr(12'h304, 32'h880);
        exc(4'd11, 32'h300, 32'h0); mret_valid = 1; irq_ext = 1;
        push(12'h341, 32'h300, 0, 0); push(12'h342, 32'hB, 0, 0);
        push(12'h343, 32'h0, 0, 0); push(12'h300, 32'h1880, 1, 32'h100);
        tick(); exc_valid = 0; mret_valid = 0; irq_ext = 0;
        busy(4);

        // pipeline write dropped mid-sequence; mepc low bits cleared
        exc(4'd4, 32'h403, 32'h55);
        push(12'h341, 32'h400, 0, 0); push(12'h342, 32'h4, 0, 0);
        push(12'h343, 32'h55, 0, 0); push(12'h300, 32'h1800, 1, 32'h100);
        tick(); exc_valid = 0;
        tick();
        sw_csr_write = 1; sw_csr_waddr = 12'h340; sw_csr_wdata = 32'h1234;
        @(negedge clk);
        chk("drop_waddr", {20'b0, csr_waddr}, 32'h342);
        chk("drop_wdata", csr_wdata, 32'h4);
        tick(); sw_csr_write = 0; sw_csr_waddr = '0; sw_csr_wdata = '0;
        busy(2);

        // reset during W_MTVAL
        exc(4'd6, 32'h500, 32'h77);
        push(12'h341, 32'h500, 0, 0); push(12'h342, 32'h6, 0, 0); push(12'h343, 32'h77, 0, 0);
        tick(); exc_valid = 0;
        tick();
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_write", {31'b0, csr_write}, 32'h0);
        chk("mid_rst_waddr", {20'b0, csr_waddr}, 32'h0);
        chk("mid_rst_wdata", csr_wdata, 32'h0);
        chk("mid_rst_rv", {31'b0, redirect_valid}, 32'h0);
        chk("mid_rst_rpc", redirect_pc, 32'h0);
        chk("mid_rst_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1; irq_ext = 1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_irq", {31'b0, stall}, 32'h0);
            tick();
        end
        irq_ext = 0;
        tick();
        chk("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
